// File: rtl/tone_fm_pkg.sv
// tone_fm_pkg: note increments, melody ROM contents and sequencer state type
package tone_fm_pkg;

    localparam logic [31:0] INC_C4 = 32'd22474;
    localparam logic [31:0] INC_D4 = 32'd25226;
    localparam logic [31:0] INC_E4 = 32'd28315;
    localparam logic [31:0] INC_F4 = 32'd29999;
    localparam logic [31:0] INC_G4 = 32'd33672;
    localparam logic [31:0] INC_A4 = 32'd37796;
    localparam logic [31:0] INC_B4 = 32'd42424;
    localparam logic [31:0] INC_C5 = 32'd44947;

    // Sum of all note durations, in 16th notes
    localparam int MELODY_SIXTEENTHS = 34;

    typedef enum logic [1:0] {ST_IDLE, ST_TONE, ST_GAP, ST_DONE} state_e;

    // Scale up to C5 and back down; the final C4 is held for a quarter note
    function automatic logic [34:0] melody_note(input logic [3:0] idx);
        case (idx)
            4'd0:         melody_note = {3'd2, INC_C4};
            4'd1, 4'd14:  melody_note = {3'd2, INC_D4};
            4'd2, 4'd13:  melody_note = {3'd2, INC_E4};
            4'd3, 4'd12:  melody_note = {3'd2, INC_F4};
            4'd4, 4'd11:  melody_note = {3'd2, INC_G4};
            4'd5, 4'd10:  melody_note = {3'd2, INC_A4};
            4'd6, 4'd9:   melody_note = {3'd2, INC_B4};
            4'd7, 4'd8:   melody_note = {3'd2, INC_C5};
            default:      melody_note = {3'd4, INC_C4};
        endcase
    endfunction

endpackage

// File: rtl/melody_rom.sv
// melody_rom: combinational lookup of note duration and phase increment
module melody_rom
    import tone_fm_pkg::*;
(
    input  logic [3:0]  idx,
    output logic [2:0]  dur,
    output logic [31:0] inc
);

    assign {dur, inc} = melody_note(idx);

endmodule

// File: rtl/melody_sequencer.sv
// melody_sequencer: plays the 16-note ROM melody as timed tone/gap phase increments
module melody_sequencer
    import tone_fm_pkg::*;
#(
    parameter int CLOCKS_PER_16TH = 6_250_000,
    parameter int GAP_CYCLES      = 250_000,
    parameter int MELODY_LENGTH   = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        loop,
    output logic [31:0] note_phase_inc,
    output logic        note_valid,
    output logic        playing,
    output logic        melody_end,
    output logic [4:0]  note_index
);

    localparam int CW = $clog2(4 * CLOCKS_PER_16TH);
    localparam logic [3:0] LAST = 4'(MELODY_LENGTH - 1);

    state_e        state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [CW-1:0] cnt_q, cnt_d, tone_len;
    logic          end_q, end_d;
    logic [31:0]   cur_inc_q;
    logic [2:0]    rom_dur;
    logic [31:0]   rom_inc;
    logic [31:0]   note_phase_inc_q, note_phase_inc_d;
    logic          note_valid_q, note_valid_d;
    logic          playing_q, playing_d;
    logic          melody_end_q, melody_end_d;
    logic [4:0]    note_index_q, note_index_d;

    // Addressed by the next index so the counter reload and increment are ready at entry
    melody_rom u_rom (
        .idx (idx_d),
        .dur (rom_dur),
        .inc (rom_inc)
    );

    // State, counter and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= ST_IDLE;
            idx_q            <= '0;
            cnt_q            <= '0;
            end_q            <= 1'b0;
            cur_inc_q        <= '0;
            note_phase_inc_q <= '0;
            note_valid_q     <= 1'b0;
            playing_q        <= 1'b0;
            melody_end_q     <= 1'b0;
            note_index_q     <= '0;
        end else begin
            state_q          <= state_d;
            idx_q            <= idx_d;
            cnt_q            <= cnt_d;
            end_q            <= end_d;
            cur_inc_q        <= rom_inc;
            note_phase_inc_q <= note_phase_inc_d;
            note_valid_q     <= note_valid_d;
            playing_q        <= playing_d;
            melody_end_q     <= melody_end_d;
            note_index_q     <= note_index_d;
        end
    end

    // Next state and index; dropping enable overrides everything
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        end_d   = 1'b0;
        if (!enable) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d = ST_TONE;
                    idx_d   = '0;
                end
                ST_TONE: state_d = (cnt_q == '0) ? ST_GAP : ST_TONE;
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        end_d   = (idx_q == LAST);
                        idx_d   = (idx_q == LAST) ? 4'd0 : idx_q + 4'd1;
                        state_d = (idx_q != LAST || loop) ? ST_TONE : ST_DONE;
                    end
                end
                default: state_d = ST_DONE;
            endcase
        end
    end

    // Duration counter: reload on entry to TONE/GAP, otherwise count down to zero
    always_comb begin
        tone_len = CW'(32'(rom_dur) * CLOCKS_PER_16TH - GAP_CYCLES - 1);
        cnt_d    = '0;
        if (state_d == state_q)
            cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : '0;
        else if (state_d == ST_TONE)
            cnt_d = tone_len;
        else if (state_d == ST_GAP)
            cnt_d = CW'(GAP_CYCLES - 1);
    end

    // Outputs present the current state one edge later, silenced at once when enable drops
    always_comb begin
        note_valid_d     = enable && state_q == ST_TONE;
        note_phase_inc_d = note_valid_d ? cur_inc_q : '0;
        playing_d        = enable && (state_q == ST_TONE || state_q == ST_GAP);
        melody_end_d     = enable && end_q;
        note_index_d     = enable ? {1'b0, idx_q} : '0;
    end

    assign note_phase_inc = note_phase_inc_q;
    assign note_valid     = note_valid_q;
    assign playing        = playing_q;
    assign melody_end     = melody_end_q;
    assign note_index     = note_index_q;

endmodule
